// File: rtl/sp_tile_mover_pkg.sv
// Shared types and constants for the scratchpad tile mover.
package sp_tile_mover_pkg;

    localparam int ROWS_PER_TILE = 4;
    localparam int SP_ROW_BITS   = 64;

    typedef enum logic {
        SP_OP_LOAD  = 1'b0,
        SP_OP_STORE = 1'b1
    } sp_op_t;

    typedef enum logic [2:0] {
        SP_IDLE,
        SP_LOAD,
        SP_LOAD_FIN,
        SP_STORE,
        SP_STORE_FIN
    } sp_mover_state_t;

endpackage

// File: rtl/sp_tile_mover_cmd_fifo.sv
// Pointer-based command FIFO with occupancy count; no push/pop bypass.
module sp_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 35
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q];

    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/sp_tile_mover.sv
// Scratchpad tile DMA: queues tile load/store commands and moves 4 rows per tile.
module sp_tile_mover
    import sp_tile_mover_pkg::*;
#(
    parameter  int NUM_TILES = 4,
    parameter  int CMD_DEPTH = 4,
    localparam int TILE_W    = $clog2(NUM_TILES)
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_op,
    input  logic [31:0]            cmd_addr,
    input  logic [TILE_W-1:0]      cmd_tile,
    output logic                   sLoad,
    output logic                   sStore,
    output logic [31:0]            load_addr,
    output logic [31:0]            store_addr,
    output logic [SP_ROW_BITS-1:0] store_data,
    input  logic [SP_ROW_BITS-1:0] load_data,
    input  logic                   sLoad_hit,
    input  logic                   sStore_hit,
    output logic                   sp_wen,
    output logic [TILE_W+1:0]      sp_waddr,
    output logic [SP_ROW_BITS-1:0] sp_wdata,
    output logic [TILE_W+1:0]      sp_raddr,
    input  logic [SP_ROW_BITS-1:0] sp_rdata,
    output logic                   done_valid,
    output logic                   done_op,
    output logic [TILE_W-1:0]      done_tile,
    output logic                   err_misalign
);

    localparam int FW = 1 + 32 + TILE_W;
    localparam logic [1:0] LAST_ROW = 2'(ROWS_PER_TILE - 1);

    sp_mover_state_t   state_q;
    logic [TILE_W-1:0] tile_q;
    logic [1:0]        row_cnt_q;
    logic [1:0]        row_q;
    logic              hit_q;
    logic              err_q;
    logic [31:0]       ld_addr_q;
    logic [31:0]       st_addr_q;

    logic              f_full;
    logic              f_empty;
    logic              f_pop;
    logic [FW-1:0]     f_dout;
    sp_op_t            f_op;
    logic [31:0]       f_addr;
    logic [TILE_W-1:0] f_tile;

    assign cmd_ready = !f_full;
    assign f_pop     = (state_q == SP_IDLE) && !f_empty;
    assign f_op      = sp_op_t'(f_dout[FW-1]);
    assign f_addr    = f_dout[FW-2 -: 32];
    assign f_tile    = f_dout[TILE_W-1:0];

    sp_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .W     (FW)
    ) u_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (cmd_valid),
        .pop   (f_pop),
        .din   ({cmd_op, cmd_addr, cmd_tile}),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= SP_IDLE;
            tile_q    <= '0;
            row_cnt_q <= '0;
            row_q     <= '0;
            hit_q     <= 1'b0;
            err_q     <= 1'b0;
            ld_addr_q <= '0;
            st_addr_q <= '0;
        end else begin
            hit_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                SP_IDLE: begin
                    if (!f_empty) begin
                        tile_q    <= f_tile;
                        row_cnt_q <= '0;
                        if (f_addr[2:0] != 3'd0) begin
                            err_q <= 1'b1;
                        end else if (f_op == SP_OP_STORE) begin
                            st_addr_q <= f_addr;
                            state_q   <= SP_STORE;
                        end else begin
                            ld_addr_q <= f_addr;
                            state_q   <= SP_LOAD;
                        end
                    end
                end
                SP_LOAD: begin
                    if (sLoad_hit) begin
                        // row_q remembers which row the next-cycle data belongs to
                        hit_q <= 1'b1;
                        row_q <= row_cnt_q;
                        if (row_cnt_q == LAST_ROW) state_q <= SP_LOAD_FIN;
                        else row_cnt_q <= row_cnt_q + 2'd1;
                    end
                end
                SP_STORE: begin
                    if (sStore_hit) begin
                        if (row_cnt_q == LAST_ROW) state_q <= SP_STORE_FIN;
                        else row_cnt_q <= row_cnt_q + 2'd1;
                    end
                end
                default: state_q <= SP_IDLE;
            endcase
        end
    end

    assign sLoad        = (state_q == SP_LOAD);
    assign sStore       = (state_q == SP_STORE);
    assign load_addr    = ld_addr_q;
    assign store_addr   = st_addr_q;
    assign sp_raddr     = sStore ? {tile_q, row_cnt_q} : '0;
    assign store_data   = sStore ? sp_rdata : '0;
    assign sp_wen       = hit_q;
    assign sp_waddr     = {tile_q, row_q};
    assign sp_wdata     = hit_q ? load_data : '0;
    assign done_valid   = (state_q == SP_LOAD_FIN) || (state_q == SP_STORE_FIN);
    assign done_op      = (state_q == SP_STORE_FIN);
    assign done_tile    = done_valid ? tile_q : '0;
    assign err_misalign = err_q;

endmodule
